// File: rtl/idle_config_ctrl_if.sv
// Board-side bundle of the idle/config controller: switches, start, enable, handoff and attract LEDs.
// The slave modport is the controller; the master modport is the board/top side.
interface idle_config_ctrl_if #(
  parameter int unsigned MODE_W   = 2,
  parameter int unsigned LEVEL_W  = 2,
  parameter int unsigned SPEED_W  = 2,
  parameter int unsigned N_COLORS = 4
) ();
  logic                i_enable;
  logic                i_start;
  logic [MODE_W-1:0]   i_mode;
  logic [LEVEL_W-1:0]  i_level;
  logic [SPEED_W-1:0]  i_speed;
  logic                i_ack;
  logic [MODE_W-1:0]   o_mode;
  logic [LEVEL_W-1:0]  o_level;
  logic [SPEED_W-1:0]  o_speed;
  logic                o_cfg_valid;
  logic                o_active;
  logic                o_done;
  logic                o_attract;
  logic [N_COLORS-1:0] o_attract_led;

  modport master (
    output i_enable, i_start, i_mode, i_level, i_speed, i_ack,
    input  o_mode, o_level, o_speed, o_cfg_valid, o_active, o_done, o_attract, o_attract_led
  );

  modport slave (
    input  i_enable, i_start, i_mode, i_level, i_speed, i_ack,
    output o_mode, o_level, o_speed, o_cfg_valid, o_active, o_done, o_attract, o_attract_led
  );
endinterface

// File: rtl/idle_config_ctrl.sv
// Idle-state controller: tracks config switches, filters the start press, hands the frozen
// config downstream over valid/ack, and rotates attract LEDs after a period of inactivity.
module idle_config_ctrl #(
  parameter int unsigned MODE_W          = 2,
  parameter int unsigned LEVEL_W         = 2,
  parameter int unsigned SPEED_W         = 2,
  parameter int unsigned START_STABLE    = 4,
  parameter int unsigned ATTRACT_TIMEOUT = 1024,
  parameter int unsigned ATTRACT_STEP    = 64,
  parameter int unsigned N_COLORS        = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  idle_config_ctrl_if.slave  bus
);

  localparam int unsigned InactW  = $clog2(ATTRACT_TIMEOUT) + 1;
  localparam int unsigned StableW = $clog2(START_STABLE) + 1;
  localparam int unsigned StepW   = $clog2(ATTRACT_STEP) + 1;

  localparam logic [InactW-1:0]   InactLast  = InactW'(ATTRACT_TIMEOUT - 1);
  localparam logic [StableW-1:0]  StableLast = StableW'(START_STABLE - 1);
  localparam logic [StepW-1:0]    StepLast   = StepW'(ATTRACT_STEP - 1);
  localparam logic [N_COLORS-1:0] LedFirst   = N_COLORS'(1);
  localparam bit                  ArmDirect  = (START_STABLE == 1);

  typedef enum logic [2:0] {
    StDisabled, StIdle, StArming, StHandoff, StRelease, StAttract
  } state_e;

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                attract_q, attract_d;
  logic [N_COLORS-1:0] led_q, led_d;
  logic [InactW-1:0]   inact_q, inact_d;
  logic [StableW-1:0]  stable_q, stable_d;
  logic [StepW-1:0]    step_q, step_d;
  logic                cfg_change;

  assign cfg_change = (bus.i_mode != mode_q) || (bus.i_level != level_q) ||
                      (bus.i_speed != speed_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    level_d     = level_q;
    speed_d     = speed_q;
    cfg_valid_d = cfg_valid_q;
    active_d    = active_q;
    done_d      = 1'b0;
    attract_d   = attract_q;
    led_d       = led_q;
    // Counters only survive while their owning state keeps them alive.
    inact_d     = '0;
    stable_d    = '0;
    step_d      = '0;

    if (!bus.i_enable) begin
      state_d     = StDisabled;
      mode_d      = '0;
      level_d     = '0;
      speed_d     = '0;
      cfg_valid_d = 1'b0;
      active_d    = 1'b0;
      attract_d   = 1'b0;
      led_d       = '0;
    end else begin
      unique case (state_q)
        StDisabled: begin
          state_d  = StIdle;
          active_d = 1'b1;
        end
        StIdle: begin
          mode_d  = bus.i_mode;
          level_d = bus.i_level;
          speed_d = bus.i_speed;
          if (bus.i_start) begin
            if (ArmDirect) begin
              state_d     = StHandoff;
              cfg_valid_d = 1'b1;
            end else begin
              state_d  = StArming;
              stable_d = StableW'(1);
            end
          end else if (!cfg_change) begin
            if (inact_q >= InactLast) begin
              state_d   = StAttract;
              attract_d = 1'b1;
              led_d     = LedFirst;
            end else begin
              inact_d = inact_q + InactW'(1);
            end
          end
        end
        StArming: begin
          mode_d  = bus.i_mode;
          level_d = bus.i_level;
          speed_d = bus.i_speed;
          if (!bus.i_start) begin
            state_d = StIdle;
          end else if (stable_q >= StableLast) begin
            state_d     = StHandoff;
            cfg_valid_d = 1'b1;
          end else begin
            stable_d = stable_q + StableW'(1);
          end
        end
        StHandoff: begin
          if (bus.i_ack) begin
            state_d     = StRelease;
            cfg_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
        StRelease: begin
          // A still-held button must not re-arm straight out of the handoff.
          if (!bus.i_start) state_d = StIdle;
        end
        StAttract: begin
          mode_d  = bus.i_mode;
          level_d = bus.i_level;
          speed_d = bus.i_speed;
          if (bus.i_start) begin
            attract_d = 1'b0;
            led_d     = '0;
            if (ArmDirect) begin
              state_d     = StHandoff;
              cfg_valid_d = 1'b1;
            end else begin
              state_d  = StArming;
              stable_d = StableW'(1);
            end
          end else if (cfg_change) begin
            state_d   = StIdle;
            attract_d = 1'b0;
            led_d     = '0;
          end else if (step_q >= StepLast) begin
            led_d = {led_q[N_COLORS-2:0], led_q[N_COLORS-1]};
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
        default: state_d = StDisabled;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StDisabled;
      mode_q      <= '0;
      level_q     <= '0;
      speed_q     <= '0;
      cfg_valid_q <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      attract_q   <= 1'b0;
      led_q       <= '0;
      inact_q     <= '0;
      stable_q    <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      level_q     <= level_d;
      speed_q     <= speed_d;
      cfg_valid_q <= cfg_valid_d;
      active_q    <= active_d;
      done_q      <= done_d;
      attract_q   <= attract_d;
      led_q       <= led_d;
      inact_q     <= inact_d;
      stable_q    <= stable_d;
      step_q      <= step_d;
    end
  end

  assign bus.o_mode        = mode_q;
  assign bus.o_level       = level_q;
  assign bus.o_speed       = speed_q;
  assign bus.o_cfg_valid   = cfg_valid_q;
  assign bus.o_active      = active_q;
  assign bus.o_done        = done_q;
  assign bus.o_attract     = attract_q;
  assign bus.o_attract_led = led_q;

endmodule

// File: tb/tb_idle_config_ctrl.sv
// Directed bench for idle_config_ctrl: start filter, handoff, attract rotation, enable/reset.
module tb_idle_config_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  idle_config_ctrl_if #(
    .MODE_W   (2),
    .LEVEL_W  (2),
    .SPEED_W  (2),
    .N_COLORS (4)
  ) bus ();

  idle_config_ctrl #(
    .MODE_W          (2),
    .LEVEL_W         (2),
    .SPEED_W         (2),
    .START_STABLE    (4),
    .ATTRACT_TIMEOUT (1024),
    .ATTRACT_STEP    (64),
    .N_COLORS        (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, {31'd0, bus.o_active}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.o_cfg_valid}, 32'd0);
    chk({tag, "_cfg"}, {26'd0, bus.o_mode, bus.o_level, bus.o_speed}, 32'd0);
    chk({tag, "_attract"}, {31'd0, bus.o_attract}, 32'd0);
    chk({tag, "_led"}, {28'd0, bus.o_attract_led}, 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_mode   = 2'd0;
    bus.i_level  = 2'd0;
    bus.i_speed  = 2'd0;
    bus.i_ack    = 1'b0;
    tick(2);
    chk_all_zero("reset");
    chk("reset_done", {31'd0, bus.o_done}, 32'd0);

    rst          = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_mode   = 2'd2;
    bus.i_level  = 2'd1;
    bus.i_speed  = 2'd3;
    tick(1);
    chk("enable_active", {31'd0, bus.o_active}, 32'd1);
    tick(1);
    chk("track_mode", {30'd0, bus.o_mode}, 32'd2);
    chk("track_level", {30'd0, bus.o_level}, 32'd1);
    chk("track_speed", {30'd0, bus.o_speed}, 32'd3);
    chk("track_valid", {31'd0, bus.o_cfg_valid}, 32'd0);

    // Ack outside HANDOFF has no effect.
    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    tick(1);
    chk("early_ack_done", {31'd0, bus.o_done}, 32'd0);
    chk("early_ack_valid", {31'd0, bus.o_cfg_valid}, 32'd0);

    // Three cycles of start is one short of qualifying.
    bus.i_start = 1'b1;
    tick(3);
    bus.i_start = 1'b0;
    tick(1);
    chk("short_press_valid", {31'd0, bus.o_cfg_valid}, 32'd0);
    tick(2);
    chk("short_press_after", {31'd0, bus.o_cfg_valid}, 32'd0);

    bus.i_start = 1'b1;
    tick(3);
    chk("arm_3_valid", {31'd0, bus.o_cfg_valid}, 32'd0);
    tick(1);
    chk("arm_4_valid", {31'd0, bus.o_cfg_valid}, 32'd1);
    bus.i_mode = 2'd0;
    tick(2);
    chk("frozen_mode", {30'd0, bus.o_mode}, 32'd2);
    chk("frozen_valid", {31'd0, bus.o_cfg_valid}, 32'd1);

    bus.i_ack = 1'b1;
    tick(1);
    bus.i_ack = 1'b0;
    chk("ack_done", {31'd0, bus.o_done}, 32'd1);
    chk("ack_valid", {31'd0, bus.o_cfg_valid}, 32'd0);
    tick(1);
    chk("done_pulse_end", {31'd0, bus.o_done}, 32'd0);
    tick(3);
    chk("release_no_rearm", {31'd0, bus.o_cfg_valid}, 32'd0);
    chk("release_hold_mode", {30'd0, bus.o_mode}, 32'd2);
    bus.i_start = 1'b0;
    tick(1);
    chk("release_exit_mode", {30'd0, bus.o_mode}, 32'd2);
    tick(1);
    chk("post_release_track", {30'd0, bus.o_mode}, 32'd0);

    // Inactivity counter restarted on the edge that noticed the mode change.
    tick(1023);
    chk("attract_not_yet", {31'd0, bus.o_attract}, 32'd0);
    tick(1);
    chk("attract_enter", {31'd0, bus.o_attract}, 32'd1);
    chk("attract_led0", {28'd0, bus.o_attract_led}, 32'h1);
    tick(63);
    chk("attract_led0_hold", {28'd0, bus.o_attract_led}, 32'h1);
    tick(1);
    chk("attract_led1", {28'd0, bus.o_attract_led}, 32'h2);
    tick(64);
    chk("attract_led2", {28'd0, bus.o_attract_led}, 32'h4);
    tick(128);
    chk("attract_wrap", {28'd0, bus.o_attract_led}, 32'h1);
    bus.i_speed = 2'd2;
    tick(1);
    chk("attract_exit", {31'd0, bus.o_attract}, 32'd0);
    chk("attract_exit_led", {28'd0, bus.o_attract_led}, 32'd0);
    chk("attract_exit_speed", {30'd0, bus.o_speed}, 32'd2);

    tick(1023);
    chk("attract2_not_yet", {31'd0, bus.o_attract}, 32'd0);
    tick(1);
    chk("attract2_enter", {31'd0, bus.o_attract}, 32'd1);

    // Start beats a simultaneous level change.
    bus.i_start = 1'b1;
    bus.i_level = 2'd2;
    tick(1);
    chk("start_prio_attract", {31'd0, bus.o_attract}, 32'd0);
    chk("start_prio_led", {28'd0, bus.o_attract_led}, 32'd0);
    chk("start_prio_level", {30'd0, bus.o_level}, 32'd2);
    tick(3);
    chk("start_prio_valid", {31'd0, bus.o_cfg_valid}, 32'd1);

    bus.i_enable = 1'b0;
    tick(1);
    chk_all_zero("dis_handoff");
    bus.i_enable = 1'b1;
    bus.i_start  = 1'b0;
    tick(2);
    chk("reenable_active", {31'd0, bus.o_active}, 32'd1);
    bus.i_start = 1'b1;
    tick(2);
    bus.i_enable = 1'b0;
    tick(1);
    chk_all_zero("dis_arming");
    bus.i_enable = 1'b1;
    bus.i_start  = 1'b0;
    tick(1);
    chk("reenable2_active", {31'd0, bus.o_active}, 32'd1);

    for (int i = 0; i < 1100 && !bus.o_attract; i++) tick(1);
    chk("attract3_enter", {31'd0, bus.o_attract}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk_all_zero("rst_attract");
    rst = 1'b0;
    tick(1);
    chk("post_rst_active", {31'd0, bus.o_active}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
